// File: rtl/fifo_wr_arbiter_if.sv
// Write-side bus between the producers, the round-robin arbiter and the FIFO write port.
// The arbiter connects through the slave modport; the producer/FIFO side uses master.
interface fifo_wr_arbiter_if #(
   parameter int unsigned num_req    = 4,
   parameter int unsigned data_width = 8
);
   localparam int unsigned id_w = (num_req > 1) ? $clog2(num_req) : 1;

   logic [num_req-1:0]            req_mask;
   logic [num_req-1:0]            req_valid;
   logic [num_req*data_width-1:0] req_data;
   logic [num_req-1:0]            req_last;
   logic [num_req-1:0]            req_ready;
   logic                          fifo_full;
   logic                          fifo_wr_en;
   logic [data_width-1:0]         fifo_data_in;
   logic [id_w-1:0]               grant_id;
   logic                          busy;

   modport master (
      output req_mask,
      output req_valid,
      output req_data,
      output req_last,
      output fifo_full,
      input  req_ready,
      input  fifo_wr_en,
      input  fifo_data_in,
      input  grant_id,
      input  busy
   );

   modport slave (
      input  req_mask,
      input  req_valid,
      input  req_data,
      input  req_last,
      input  fifo_full,
      output req_ready,
      output fifo_wr_en,
      output fifo_data_in,
      output grant_id,
      output busy
   );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among num_req packet producers.
// A grant lasts for one packet or max_burst words, then priority rotates past the grantee.
module fifo_wr_arbiter #(
   parameter int unsigned num_req    = 4,
   parameter int unsigned data_width = 8,
   parameter int unsigned max_burst  = 16
) (
   input logic              clk,
   input logic              reset,
   fifo_wr_arbiter_if.slave bus
);
   localparam int unsigned id_w  = (num_req > 1) ? $clog2(num_req) : 1;
   localparam int unsigned cnt_w = $clog2(max_burst + 1);

   typedef enum logic [0:0] {StIdle, StGrant} state_e;

   state_e            state_q;
   logic [id_w-1:0]   grant_id_q;
   logic [id_w-1:0]   rr_ptr_q;
   logic [cnt_w-1:0]  beat_cnt_q;
   logic              busy_q;

   logic [data_width-1:0] words [num_req];
   logic [num_req-1:0]    eligible;
   logic                  any_eligible;
   logic [id_w-1:0]       scan_idx;
   logic [id_w-1:0]       sel_id;
   logic                  xfer;
   logic                  release_grant;
   logic [id_w-1:0]       next_ptr;

   for (genvar gi = 0; gi < num_req; gi++) begin : g_unpack
      assign words[gi] = bus.req_data[gi*data_width +: data_width];
   end

   assign eligible     = bus.req_valid & bus.req_mask;
   assign any_eligible = |eligible;

   // Scan downward so the lowest offset from rr_ptr is the last (winning) assignment.
   always_comb begin
      sel_id   = '0;
      scan_idx = '0;
      for (int k = num_req - 1; k >= 0; k--) begin
         scan_idx = id_w'((32'(rr_ptr_q) + 32'(k)) % num_req);
         if (eligible[scan_idx]) begin
            sel_id = scan_idx;
         end
      end
   end

   // Write side is combinational from the grant; reset blocks any write in its cycle.
   always_comb begin
      bus.req_ready    = '0;
      bus.fifo_wr_en   = 1'b0;
      bus.fifo_data_in = '0;
      if (state_q == StGrant && !reset) begin
         bus.fifo_data_in          = words[grant_id_q];
         bus.req_ready[grant_id_q] = ~bus.fifo_full;
         bus.fifo_wr_en            = bus.req_valid[grant_id_q] & ~bus.fifo_full;
      end
   end

   assign xfer          = bus.fifo_wr_en;
   assign release_grant = bus.req_last[grant_id_q] | (beat_cnt_q == cnt_w'(max_burst - 1));
   assign next_ptr      = (grant_id_q == id_w'(num_req - 1)) ? '0 : grant_id_q + 1'b1;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= StIdle;
         grant_id_q <= '0;
         rr_ptr_q   <= '0;
         beat_cnt_q <= '0;
         busy_q     <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (any_eligible) begin
                  state_q    <= StGrant;
                  grant_id_q <= sel_id;
                  beat_cnt_q <= '0;
                  busy_q     <= 1'b1;
               end
            end
            StGrant: begin
               if (xfer) begin
                  if (release_grant) begin
                     state_q    <= StIdle;
                     rr_ptr_q   <= next_ptr;
                     beat_cnt_q <= '0;
                     busy_q     <= 1'b0;
                  end else begin
                     beat_cnt_q <= beat_cnt_q + 1'b1;
                  end
               end
            end
            default: begin
               state_q <= StIdle;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.grant_id = grant_id_q;
   assign bus.busy     = busy_q;

   a_ready_onehot : assert property (@(posedge clk) $onehot0(bus.req_ready));
   a_wr_not_full  : assert property (@(posedge clk) bus.fifo_wr_en |-> !bus.fifo_full);
   a_wr_has_ready : assert property (@(posedge clk) bus.fifo_wr_en |-> bus.req_ready[grant_id_q]);
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized bench for fifo_wr_arbiter against a cycle-level model of the grant rules.
module tb_fifo_wr_arbiter;
   localparam int unsigned N  = 4;
   localparam int unsigned W  = 8;
   localparam int unsigned MB = 16;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   fifo_wr_arbiter_if #(.num_req(N), .data_width(W)) bus ();

   fifo_wr_arbiter #(.num_req(N), .data_width(W), .max_burst(MB)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Producers: words left in current packet and running word counter.
   int remain   [N];
   int word_idx [N];

   // Model: owner = producer currently holding the port, -1 when none.
   int   owner, gid, ptr, sent;
   logic exp_wr;
   logic just_reset;

   logic [N-1:0] v_valid, v_last, v_mask;
   logic         v_full, v_reset;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] word_of(input int i);
      return W'((i << 6) | (word_idx[i] & 63));
   endfunction

   task automatic drive(input logic [N-1:0] mask, input int vpct, input int fpct,
                        input int rpct, input int lmin, input int lmax);
      logic [N*W-1:0] d;
      d = '0;
      for (int i = 0; i < N; i++) begin
         if (remain[i] == 0) remain[i] = int'($urandom_range(lmax, lmin));
         v_valid[i] = (int'($urandom_range(99, 0)) < vpct);
         v_last[i]  = (remain[i] == 1);
         d[i*W +: W] = word_of(i);
      end
      v_mask  = mask;
      v_full  = (int'($urandom_range(99, 0)) < fpct);
      v_reset = (int'($urandom_range(99, 0)) < rpct);
      bus.req_mask  = v_mask;
      bus.req_valid = v_valid;
      bus.req_last  = v_last;
      bus.req_data  = d;
      bus.fifo_full = v_full;
      reset         = v_reset;
   endtask

   task automatic compare();
      logic [N-1:0] exp_ready;
      exp_ready = '0;
      exp_wr    = 1'b0;
      if (owner >= 0 && !v_reset) begin
         exp_ready[owner] = ~v_full;
         exp_wr           = v_valid[owner] & ~v_full;
      end
      check_eq("busy", 32'(bus.busy), 32'(owner >= 0));
      check_eq("grant_id", 32'(bus.grant_id), gid);
      check_eq("fifo_wr_en", 32'(bus.fifo_wr_en), 32'(exp_wr));
      check_eq("req_ready", 32'(bus.req_ready), 32'(exp_ready));
      if (exp_wr) check_eq("fifo_data_in", 32'(bus.fifo_data_in), 32'(word_of(owner)));
      else if (just_reset) check_eq("data_after_reset", 32'(bus.fifo_data_in), 0);
   endtask

   task automatic update();
      just_reset = v_reset;
      if (v_reset) begin
         owner = -1;
         gid   = 0;
         ptr   = 0;
         sent  = 0;
      end else if (owner < 0) begin
         for (int k = 0; k < N; k++) begin
            int j;
            j = (ptr + k) % N;
            if (owner < 0 && v_valid[j] && v_mask[j]) begin
               owner = j;
               gid   = j;
               sent  = 0;
            end
         end
      end else if (exp_wr) begin
         sent++;
         remain[owner]--;
         word_idx[owner]++;
         if (v_last[owner] || sent == MB) begin
            ptr   = (owner + 1) % N;
            owner = -1;
         end
      end
   endtask

   task automatic run_phase(input logic [N-1:0] mask, input int vpct, input int fpct,
                            input int rpct, input int lmin, input int lmax, input int ncyc);
      for (int c = 0; c < ncyc; c++) begin
         drive(mask, vpct, fpct, rpct, lmin, lmax);
         @(negedge clk);
         compare();
         @(posedge clk);
         update();
         #1;
      end
   endtask

   initial begin
      reset         = 1'b1;
      bus.req_mask  = '0;
      bus.req_valid = '0;
      bus.req_last  = '0;
      bus.req_data  = '0;
      bus.fifo_full = 1'b0;
      v_reset       = 1'b1;
      for (int i = 0; i < N; i++) begin
         remain[i]   = 0;
         word_idx[i] = 0;
      end
      repeat (2) @(posedge clk);
      owner      = -1;
      gid        = 0;
      ptr        = 0;
      sent       = 0;
      just_reset = 1'b1;
      #1;
      run_phase(4'hF,   0,   0, 0, 1,  1,   10);   // idle after reset
      run_phase(4'b0101, 100, 0, 0, 3,  3,   60);  // 3-word packets from 0 and 2
      run_phase(4'b1010, 100, 0, 0, 40, 40, 200);  // long packets hit max_burst
      run_phase(4'hF,   100, 0,  0, 1,  40, 300);
      run_phase(4'hF,   80,  30, 0, 1,  8, 1000);  // FIFO backpressure
      for (int p = 0; p < 6; p++) begin
         run_phase(N'($urandom), 70, 20, 2, 1, 24, 600);
      end
      run_phase(4'hF,   60,  20, 5, 1,  6, 1000);  // frequent mid-packet resets
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
